io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//   Shares the single IO device port (LED/KEY register block) between two bus
//   masters: m0 = CPU data port, m1 = debug/monitor port. It runs a round-robin
//   req/ack handshake, performs one IO access at a time, and drives the IO
//   device's ce/we/addr/wtData. It registers the read data and rejects
//   unmapped or illegal accesses with an error flag.
//   It sits between the CPU/debug masters and the IO device, on the IO side
//   of the address decoder.
// PARAMETERS
//   LED_ADDR  32'h0000_FFF0  address of the LED register (read/write)
//   KEY_ADDR  32'h0000_FFF4  address of the KEY register (read only)
// PORTS
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   m0_req     in   1   m0 access request; held high until m0_ack
//   m0_we      in   1   m0 write (1) / read (0)
//   m0_addr    in   32  m0 byte address
//   m0_wdata   in   32  m0 write data
//   m0_rdata   out  32  m0 read data, valid while m0_ack=1
//   m0_ack     out  1   one-cycle completion pulse to m0
//   m0_err     out  1   error qualifier, valid while m0_ack=1
//   m1_*       --   --  identical set for m1 (req, we, addr, wdata, rdata, ack, err)
//   io_ce      out  1   IO device chip enable
//   io_we      out  1   IO device write enable
//   io_addr    out  32  IO device address
//   io_wdata   out  32  IO device write data
//   io_rdata   in   32  IO device combinational read data
//   gnt_id     out  1   master owning the current transaction (0=m0, 1=m1)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, prio=m0, all outputs 0.
//   FSM, all transitions on posedge clk:
//   - IDLE: no req -> stay. Any req -> pick winner, latch winner's we/addr/wdata,
//     set gnt_id.
//     * Only one req: that master wins.
//     * Both req: the master named by prio wins.
//     * Decode latched addr. LED_ADDR, any op -> ACCESS. KEY_ADDR read -> ACCESS.
//     * Otherwise (unmapped address, or write to KEY) -> RESP with err pending.
//   - ACCESS (1 cycle): io_ce=1, io_we=latched we, io_addr/io_wdata=latched.
//     * Capture io_rdata into the read-data register on the exiting edge
//       (forced to 0 for writes).
//     * Next state -> RESP.
//   - RESP (1 cycle): winner's ack=1, rdata=captured, err=pending flag.
//     * Other master's ack/err=0.
//     * prio <= other master.
//     * Next state -> IDLE.
//   Outputs in IDLE/RESP: io_ce=0, io_we=0. io_addr/io_wdata hold the last
//   latched value. rdata is 0 whenever ack=0.
//   Latency: req high at edge N (IDLE) -> ack high in cycle after edge N+2
//   (legal access), or after edge N+1 (error access).
//   Throughput: one access per 3 cycles per legal request; no back-to-back
//   grant without an IDLE cycle.
//   Handshake rules:
//   - A master must keep req/we/addr/wdata stable until its ack. Inputs are
//     sampled only in IDLE.
//   - A master dropping req before ack does not abort the transaction; the
//     transaction completes and ack still pulses.
//   - A req still high in the IDLE cycle after its own ack is a new request.
//   Fairness: under continuous requests from both masters, grants alternate
//   m0, m1, m0, ...
//   Error access: IO device never sees ce=1; ack with err=1, rdata=0.
//   Reset mid-transaction: abort immediately. io_ce drops asynchronously, no
//   ack is issued, prio returns to m0.
// TESTING
//   1. m0 write LED_ADDR, data 32'h0000_A5A5 -> one ACCESS cycle with io_ce=1,
//      io_we=1, io_wdata=A5A5; m0_ack 2 cycles after grant; err=0.
//   2. m1 read KEY_ADDR with io_rdata=32'h1 -> io_ce=1, io_we=0;
//      m1_rdata=32'h1 with m1_ack; err=0.
//   3. m0 and m1 req same cycle out of reset, both held high for 4
//      transactions -> grant order m0, m1, m0, m1; each ack a single pulse.
//   4. m0 write KEY_ADDR, then m0 read 32'h0000_1000 -> io_ce never asserted;
//      m0_ack=1, m0_err=1, m0_rdata=0, one cycle after sample.
//   5. rst_n low during ACCESS -> io_ce=0 immediately, no ack; after release,
//      a single m1 req is served normally; m0 has priority on the next tie.
//   6. m1 drops req during ACCESS -> transaction completes; m1_ack pulses once;
//      arbiter returns to IDLE with no further grant.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Purpose     : round-robin arbiter sharing the LED/KEY IO register port between two bus masters.
// Latency     : legal access acks two edges after the request is sampled in IDLE, rejected access one edge after.
// Backpressure: req is level-held until ack; one transaction in flight, the loser simply waits in IDLE.
//
// Ports
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   m0_req/we/addr/wdata             master 0 (CPU data port) request side, held stable until m0_ack
//   m0_rdata/ack/err                 master 0 response: one-cycle ack, rdata and err valid with ack, 0 otherwise
//   m1_*                             identical set for master 1 (debug/monitor port)
//   io_ce/we/addr/wdata              IO device strobe and latched request fields
//   io_rdata                         IO device combinational read data
//   gnt_id                           owner of the current/last transaction (0 = m0, 1 = m1)
module io_bus_arbiter #(
    parameter logic [31:0] LED_ADDR = 32'h0000_FFF0,
    parameter logic [31:0] KEY_ADDR = 32'h0000_FFF4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        io_ce,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,

    output logic        gnt_id
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic        prio_q,  prio_d;    // master that wins a tie
    logic        gnt_q,   gnt_d;     // owner of the transaction
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;     // rejected access, reported with ack

    // ------------------------------------------------------------------
    // Winner selection and address decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic        any_req;
    logic        win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;

    always_comb begin
        any_req = m0_req | m1_req;
        // A lone requester always wins; prio only breaks a tie.
        if (m0_req && m1_req) begin
            win = prio_q;
        end else begin
            win = m1_req;
        end
        sel_we    = win ? m1_we    : m0_we;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        // LED is read/write, KEY is read-only, everything else is unmapped.
        sel_legal = (sel_addr == LED_ADDR) ||
                    ((sel_addr == KEY_ADDR) && !sel_we);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // Cleared here so a rejected access returns rdata = 0.
                    rdata_d = '0;
                    err_d   = !sel_legal;
                    // Rejected accesses skip ACCESS so the device never sees ce.
                    state_d = sel_legal ? ST_ACCESS : ST_RESP;
                end
            end

            ST_ACCESS: begin
                rdata_d = we_q ? '0 : io_rdata;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // Hand the tie-break to the master that was not just served.
                prio_d  = ~gnt_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from state so a reset drops io_ce at once
    // ------------------------------------------------------------------
    logic in_access;
    logic in_resp;

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

    assign io_ce    = in_access;
    assign io_we    = in_access & we_q;
    assign io_addr  = addr_q;
    assign io_wdata = wdata_q;
    assign gnt_id   = gnt_q;

    assign m0_ack   = in_resp & ~gnt_q;
    assign m1_ack   = in_resp &  gnt_q;
    assign m0_err   = m0_ack & err_q;
    assign m1_err   = m1_ack & err_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule
